song_reader: RTL
================

Name: song_reader

Overview:
- Sequencer that walks a song stored in a synchronous song ROM and feeds notes one at a time to the note player.
- Drives the note player's load interface (note, duration, load strobe) and consumes its note-finished indication.
- Sits between the top-level music player control (play/pause, song select) and note_player; signals end of song upward.

Parameters:
- NOTE_W, 6, note code width; matches frequency ROM address width.
- DUR_W, 6, duration width in 1/48 s beats.
- IDX_W, 5, note index width; 32 entries per song.
- SONG_W, 2, song select width; 4 songs.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- play  in  1  level; 1 = advance through the song, 0 = pause.
- song  in  SONG_W  selected song.
- note_done  in  1  level from note player; 1 when its remaining duration is zero.
- new_note  out  1  one-cycle load strobe to the note player.
- note  out  NOTE_W  note code, valid when new_note is high and held afterwards.
- duration  out  DUR_W  duration in beats, valid when new_note is high and held afterwards.
- song_done  out  1  one-cycle pulse when the song ends.
- note_index  out  IDX_W  current entry index (debug).

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE, index 0, song_q 0, new_note 0, song_done 0, note 0, duration 0.
- ROM word is {note[11:6], duration[5:0]}. Address is {song_q, index}. ROM has 1-cycle read latency.
- All outputs are registered.
- IDLE:
  - index = 0.
  - If play=1: capture song into song_q and go to FETCH.
- FETCH: present the address; go to RDATA.
- RDATA (ROM data valid):
  - If ROM duration == 0: end of song; go to DONE.
  - Else: register note/duration from ROM and go to LOAD.
- LOAD: new_note = 1 for exactly this cycle; go to GUARD.
- GUARD: one cycle in which note_done is ignored, because the player's counter has not yet reloaded. Go to WAIT_NOTE.
- WAIT_NOTE:
  - If play=1 and note_done=1 and index == 31: go to DONE.
  - If play=1 and note_done=1 and index < 31: index += 1, go to FETCH.
  - Else stay.
- DONE: song_done = 1 for one cycle; index = 0; go to IDLE.
- Latency: play sampled high in IDLE at edge N gives new_note high during the cycle after edge N+3. Note-to-note gap is 4 cycles after the note_done qualifying edge.
- Pause (play=0):
  - State frozen in FETCH, RDATA and WAIT_NOTE; no new_note is issued.
  - LOAD and GUARD complete regardless, so a strobe is never truncated.
  - Resume continues from the held index.
- Song change (song != song_q in any non-IDLE state):
  - Abort to IDLE next edge with index 0.
  - No song_done and no new_note.
  - Takes priority over all other transitions.
- Reset mid-operation overrides everything. Any pending strobe is dropped.
- Simultaneous note_done and song change: song change wins.
- note_done already high in LOAD/GUARD: ignored.

Optional Feature:
- Macro: SONG_READER_LOOP_EN.
- Defined:
  - DONE still pulses song_done.
  - Then goes to FETCH with index 0, so the same song repeats while play=1.
  - A song whose entry 0 has duration 0 does not loop; it goes to IDLE to avoid a livelock.
- Undefined: DONE returns to IDLE, and play must be sampled again to restart.

Decomposition:
- Shared package:
  - State encoding enum (IDLE, FETCH, RDATA, LOAD, GUARD, WAIT_NOTE, DONE).
  - NOTE_W, DUR_W, IDX_W, SONG_W constants.
  - ROM field slice positions.
- Sub-module: song_rom (address {song, index}, dout 12 bits, registered, initialised from the song image).
- The state register uses the existing dffr flop.

Test Plan:
- Image: song0 idx0={20,12}, idx1={22,6}, idx2={0,0}.
- Basic playback: reset, play=1, song=0.
  - new_note pulses once with note=20, duration=12.
  - Hold note_done=0 for 10 cycles, then 1: next new_note carries note=22, duration=6.
  - Next note_done: song_done pulses once and the reader returns to IDLE.
- Guard: note_done held 1 throughout. Exactly one new_note per 5-cycle period; entry 0 is never skipped.
- Pause: play=0 during WAIT_NOTE of idx0, with note_done=1 for 20 cycles. No new_note. Set play=1: new_note with note=22 four cycles later.
- Song change: switch song 0→1 during WAIT_NOTE.
  - Next strobe is song1 idx0.
  - No song_done.
  - note_index reads 0.
- Full song: song3 with 32 nonzero entries. 32 new_note pulses, then song_done on the 32nd note_done. With SONG_READER_LOOP_EN, a 33rd strobe carries idx0 data.
- Reset during LOAD: new_note falls in the next cycle; all outputs return to 0 and the state returns to IDLE.

Source files
------------

// File: rtl/song_reader_pkg.sv
// rtl/song_reader_pkg.sv - shared widths, ROM word layout and sequencer state encoding for song_reader
package song_reader_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int IDX_W  = 5;
    localparam int SONG_W = 2;

    localparam int ROM_W  = NOTE_W + DUR_W;
    localparam int ADDR_W = SONG_W + IDX_W;

    // ROM word is {note, duration}
    localparam int DUR_LSB  = 0;
    localparam int DUR_MSB  = DUR_W - 1;
    localparam int NOTE_LSB = DUR_W;
    localparam int NOTE_MSB = ROM_W - 1;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RDATA,
        LOAD,
        GUARD,
        WAIT_NOTE,
        DONE
    } state_t;

endpackage

// File: rtl/song_reader_if.sv
// rtl/song_reader_if.sv - control and note-player signals of song_reader; master is the reader side
interface song_reader_if;
    import song_reader_pkg::*;

    logic              play;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              song_done;
    logic [IDX_W-1:0]  note_index;

    modport master (
        input  play, song, note_done,
        output new_note, note, duration, song_done, note_index
    );

    modport slave (
        output play, song, note_done,
        input  new_note, note, duration, song_done, note_index
    );
endinterface

// File: rtl/dffr.sv
// rtl/dffr.sv - generic flop with synchronous active-high reset to zero
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (r) q <= '0;
        else   q <= d;
    end
endmodule

// File: rtl/song_rom.sv
// rtl/song_rom.sv - song image ROM, address {song, index}, one-cycle registered read
module song_rom
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ROM_W-1:0]  dout_o
);
    // Unlisted entries read as zero, which terminates the song.
    function automatic logic [ROM_W-1:0] image(input logic [ADDR_W-1:0] a);
        logic [IDX_W-1:0] idx;
        logic [DUR_W-1:0] dur;
        idx   = a[IDX_W-1:0];
        dur   = {1'b0, idx} + 6'd1;
        image = '0;
        case (a[ADDR_W-1:IDX_W])
            2'd0: begin
                if (idx == 5'd0) image = {6'd20, 6'd12};
                if (idx == 5'd1) image = {6'd22, 6'd6};
            end
            2'd1: begin
                if (idx == 5'd0) image = {6'd30, 6'd3};
                if (idx == 5'd1) image = {6'd31, 6'd4};
            end
            2'd3:    image = {1'b1, idx, dur};
            default: image = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        dout_o <= image(addr_i);
    end
endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - walks a song in song_rom and strobes notes into the note player
// SONG_READER_LOOP_EN: after the last entry, restart the same song instead of returning to IDLE.
module song_reader
    import song_reader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);
    state_t              state_q, state_d;
    logic [2:0]          state_raw;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                new_note_q, new_note_d;
    logic                song_done_q, song_done_d;
    logic [ROM_W-1:0]    rom_data;

    dffr #(.WIDTH(3)) u_state (
        .clk (clk),
        .r   (reset),
        .d   (state_d),
        .q   (state_raw)
    );
    assign state_q = state_t'(state_raw);

    song_rom u_rom (
        .clk    (clk),
        .addr_i ({song_q, index_q}),
        .dout_o (rom_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q     <= '0;
            song_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            index_q     <= index_d;
            song_q      <= song_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        song_d      = song_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        // A song change outranks every other transition, including a pending strobe.
        if (state_q != IDLE && bus.song != song_q) begin
            state_d = IDLE;
            index_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    index_d = '0;
                    if (bus.play) begin
                        song_d  = bus.song;
                        state_d = FETCH;
                    end
                end
                FETCH: if (bus.play) state_d = RDATA;
                RDATA: begin
                    if (bus.play) begin
                        if (rom_data[DUR_MSB:DUR_LSB] == '0) begin
                            state_d = DONE;
                        end else begin
                            note_d  = rom_data[NOTE_MSB:NOTE_LSB];
                            dur_d   = rom_data[DUR_MSB:DUR_LSB];
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    new_note_d = 1'b1;
                    state_d    = GUARD;
                end
                // Player counter reloads here, so a stale note_done must not be seen.
                GUARD: state_d = WAIT_NOTE;
                WAIT_NOTE: begin
                    if (bus.play && bus.note_done) begin
                        if (index_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            index_d = index_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    song_done_d = 1'b1;
                    index_d     = '0;
`ifdef SONG_READER_LOOP_EN
                    // index still 0 here means entry 0 was the terminator: looping would livelock.
                    state_d     = (index_q != '0) ? FETCH : IDLE;
`else
                    state_d     = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.new_note   = new_note_q;
    assign bus.note       = note_q;
    assign bus.duration   = dur_q;
    assign bus.song_done  = song_done_q;
    assign bus.note_index = index_q;
endmodule
